move_scheduler: RTL

Frame-synchronous sequencer for the player movement datapath. Derives a single-cycle `update` strobe from the VGA scan counters at the start of vertical blanking, debounces the four active-low direction buttons on frame boundaries, and runs the direction state machine. It drives the `update` clock-enable and a registered direction code into the movement datapath, so player position changes only outside the visible frame.

---
 rtl/move_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
`default_nettype none
// move_scheduler: frame-synchronous movement sequencer. Emits one update strobe per
// FRAME_DIV frames at the start of vertical blanking, with a debounced, registered direction.
module move_scheduler #(
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_DIV  = 2,
  parameter int DEB_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_n,
  input  logic       down_n,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       pause,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  output logic       update,
  output logic [2:0] dir,
  output logic       moving
);

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    STAY  = 3'd4
  } dir_t;

  localparam logic [9:0] V_LINE   = 10'(V_ACTIVE);
  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [2:0] DEB_MAX  = 3'(DEB_FRAMES);

  // Button bit order throughout: [0]=up, [1]=down, [2]=left, [3]=right.
  logic [3:0] buttons_n;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [2:0] cnt [4];
  logic [3:0] pressed;
  logic [3:0] div;
  logic       cond;
  logic       cond_d;
  logic       tick;
  logic       step;
  logic       step_d;
  dir_t       state;
  dir_t       next_state;

  assign buttons_n = {right_n, left_n, down_n, up_n};
  assign cond      = (xCount == 10'd0) && (yCount == V_LINE);
  // Edge-detect so counters parked on the trigger point still give a single tick.
  assign tick      = cond && !cond_d;
  assign step      = tick && !pause && (div == DIV_LAST);
  assign dir       = state;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      pressed[b] = (cnt[b] == DEB_MAX);
    end
  end

  // A moving state never turns directly; it always drops back to STAY first.
  always_comb begin
    next_state = STAY;
    case (state)
      UP:      next_state = pressed[0] ? UP    : STAY;
      DOWN:    next_state = pressed[1] ? DOWN  : STAY;
      LEFT:    next_state = pressed[2] ? LEFT  : STAY;
      RIGHT:   next_state = pressed[3] ? RIGHT : STAY;
      default: begin
        if (pressed[0])      next_state = UP;
        else if (pressed[1]) next_state = DOWN;
        else if (pressed[2]) next_state = LEFT;
        else if (pressed[3]) next_state = RIGHT;
        else                 next_state = STAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 4'hF;
      sync2  <= 4'hF;
      cond_d <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= 3'd0;
      end
      div    <= 4'd0;
      step_d <= 1'b0;
      state  <= STAY;
      update <= 1'b0;
      moving <= 1'b0;
    end else begin
      sync1  <= buttons_n;
      sync2  <= sync1;
      cond_d <= cond;
      step_d <= step;
      if (tick) begin
        for (int b = 0; b < 4; b++) begin
          if (!sync2[b]) begin
            cnt[b] <= (cnt[b] == DEB_MAX) ? cnt[b] : cnt[b] + 3'd1;
          end else begin
            cnt[b] <= 3'd0;
          end
        end
        if (!pause) begin
          div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        end
      end
      // A step already pending when pause rises is allowed to complete.
      update <= step_d;
      if (step_d) begin
        state  <= next_state;
        moving <= (next_state != STAY);
      end
    end
  end

endmodule
`default_nettype wire
